bip_control_unit: RTL

//  Instruction sequencer for the BIP core. Drives the program-memory address (PC), takes the

---
 rtl/bip_control_unit.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/bip_control_unit.sv
// BIP instruction sequencer: FETCH/EXEC loop, opcode decode,
// control strobes, sticky illegal flag and retired-instruction count.
module bip_control_unit #(
  parameter int ADDRESS_BITS = 11,
  parameter int DATA_BITS    = 16,
  parameter int OPCODE_BITS  = 5,
  parameter int COUNT_BITS   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [DATA_BITS-1:0]    i_instruction,
  output logic [ADDRESS_BITS-1:0] o_pc,
  output logic [ADDRESS_BITS-1:0] o_operand,
  output logic                    o_wr_ram,
  output logic                    o_rd_ram,
  output logic                    o_wr_acc,
  output logic [1:0]              o_sel_a,
  output logic                    o_sel_b,
  output logic                    o_alu_op,
  output logic                    o_halted,
  output logic                    o_illegal,
  output logic [COUNT_BITS-1:0]   o_instr_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

  localparam logic [OPCODE_BITS-1:0] OP_HLT  = OPCODE_BITS'(0);
  localparam logic [OPCODE_BITS-1:0] OP_STO  = OPCODE_BITS'(1);
  localparam logic [OPCODE_BITS-1:0] OP_LD   = OPCODE_BITS'(2);
  localparam logic [OPCODE_BITS-1:0] OP_LDI  = OPCODE_BITS'(3);
  localparam logic [OPCODE_BITS-1:0] OP_ADD  = OPCODE_BITS'(4);
  localparam logic [OPCODE_BITS-1:0] OP_ADDI = OPCODE_BITS'(5);
  localparam logic [OPCODE_BITS-1:0] OP_SUB  = OPCODE_BITS'(6);
  localparam logic [OPCODE_BITS-1:0] OP_SUBI = OPCODE_BITS'(7);

  state_t                  state_q, state_d;
  logic [ADDRESS_BITS-1:0] pc_q, pc_d;
  logic                    illegal_q, illegal_d;
  logic [COUNT_BITS-1:0]   count_q, count_d;

  logic [OPCODE_BITS-1:0]  opcode;
  logic                    exec;
  logic                    is_hlt;
  logic                    is_bad;

  assign opcode    = i_instruction[DATA_BITS-1 -: OPCODE_BITS];
  assign exec      = (state_q == S_EXEC);
  assign o_operand = i_instruction[ADDRESS_BITS-1:0];
  assign o_pc      = pc_q;
  assign o_halted  = (state_q == S_HALT);
  assign o_illegal = illegal_q;
  assign o_instr_count = count_q;

  // Decode the opcode into strobes/selects; everything stays low outside EXEC.
  always_comb begin
    o_wr_ram = 1'b0;
    o_rd_ram = 1'b0;
    o_wr_acc = 1'b0;
    o_sel_a  = 2'b00;
    o_sel_b  = 1'b0;
    o_alu_op = 1'b0;
    is_hlt   = 1'b0;
    is_bad   = 1'b0;
    if (exec) begin
      case (opcode)
        OP_HLT: is_hlt = 1'b1;
        OP_STO: o_wr_ram = 1'b1;
        OP_LD: begin
          o_rd_ram = 1'b1;
          o_wr_acc = 1'b1;
        end
        OP_LDI: begin
          o_wr_acc = 1'b1;
          o_sel_a  = 2'b01;
        end
        OP_ADD: begin
          o_rd_ram = 1'b1;
          o_wr_acc = 1'b1;
          o_sel_a  = 2'b10;
        end
        OP_ADDI: begin
          o_wr_acc = 1'b1;
          o_sel_a  = 2'b10;
          o_sel_b  = 1'b1;
        end
        OP_SUB: begin
          o_rd_ram = 1'b1;
          o_wr_acc = 1'b1;
          o_sel_a  = 2'b10;
          o_alu_op = 1'b1;
        end
        OP_SUBI: begin
          o_wr_acc = 1'b1;
          o_sel_a  = 2'b10;
          o_sel_b  = 1'b1;
          o_alu_op = 1'b1;
        end
        default: is_bad = 1'b1;
      endcase
    end
  end

  // Next-state logic for the sequencer, PC, illegal flag and counter.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    illegal_d = illegal_q;
    count_d   = count_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (count_q != {COUNT_BITS{1'b1}}) begin
          count_d = count_q + 1'b1;
        end
        if (is_bad) illegal_d = 1'b1;
        if (is_hlt) begin
          state_d = S_HALT;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state registers with immediate abort on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

endmodule
